// File: rtl/sequence_store.sv
// Simon Says pattern memory: grows one symbol per round, replays it for the
// display sequencer and checks player input against it.
module sequence_store #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 16,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             append,
  input  logic [WIDTH-1:0] append_data,
  input  logic             rd_start,
  input  logic             rd_next,
  input  logic             chk_valid,
  input  logic [WIDTH-1:0] chk_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             rd_last,
  output logic             chk_ok,
  output logic             chk_err,
  output logic [LW-1:0]    length,
  output logic             full,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [LW-1:0]    ptr;
  logic             active;
  logic [WIDTH-1:0] cur;
  logic             is_last;
  logic             match;
  logic             wr_en;
  logic             step;

  assign cur      = mem[ptr[AW-1:0]];
  assign full     = (length == LW'(DEPTH));
  assign is_last  = (ptr == length - LW'(1));
  assign match    = (chk_data == cur);
  assign wr_en    = append && !clear && !full;
  assign step     = active && (chk_valid || rd_next);
  assign rd_valid = active;
  assign rd_last  = active && is_last;
  assign rd_data  = active ? cur : '0;

  // Storage is intentionally left unreset; length qualifies every read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[length[AW-1:0]] <= append_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      length   <= '0;
      ptr      <= '0;
      active   <= 1'b0;
      chk_ok   <= 1'b0;
      chk_err  <= 1'b0;
      overflow <= 1'b0;
    end else if (clear) begin
      length   <= '0;
      ptr      <= '0;
      active   <= 1'b0;
      chk_ok   <= 1'b0;
      chk_err  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (append) begin
        if (!full) length <= length + LW'(1);
        else       overflow <= 1'b1;
      end
      chk_ok  <= chk_valid && active && match;
      chk_err <= chk_valid && !(active && match);
      if (rd_start) begin
        ptr    <= '0;
        active <= (length != '0);
      end else if (step) begin
        // A wrong symbol ends the pass just like reaching the end.
        if (is_last || (chk_valid && !match)) begin
          ptr    <= '0;
          active <= 1'b0;
        end else begin
          ptr <= ptr + LW'(1);
        end
      end
    end
  end

endmodule
